rect_fill_engine: RTL and testbench

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

---
 rtl/fill_pkg.sv | 40 ++++
 rtl/fill_pixel_merge.sv | 44 ++++
 rtl/rect_fill_engine.sv | 169 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared types and derived frame-buffer constants for the rectangle fill engine.
package fill_pkg;

  localparam int unsigned DEF_FB_W      = 640;
  localparam int unsigned DEF_FB_H      = 480;
  localparam int unsigned DEF_BURST_PIX = 64;
  localparam int unsigned COORD_W       = 16;

  localparam int unsigned WORDS_PER_ROW = DEF_FB_W / DEF_BURST_PIX;
  localparam int unsigned LAYER_WORDS   = WORDS_PER_ROW * DEF_FB_H;

  typedef enum logic [1:0] {
    TexSolid   = 2'd0,
    TexChecker = 2'd1,
    TexHStripe = 2'd2,
    TexVStripe = 2'd3
  } texture_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRd,
    StRwait,
    StWr,
    StNext,
    StFin
  } state_e;

  function automatic int unsigned calc_words_per_row(input int unsigned fb_w,
                                                     input int unsigned burst_pix);
    return fb_w / burst_pix;
  endfunction

  function automatic int unsigned calc_layer_words(input int unsigned fb_w,
                                                   input int unsigned fb_h,
                                                   input int unsigned burst_pix);
    return calc_words_per_row(fb_w, burst_pix) * fb_h;
  endfunction

endpackage

// File: rtl/fill_pixel_merge.sv
// Combinational read-modify-write merge: replaces in-span pixels of one SRAM word
// with the textured fill colour, leaving the rest of the word untouched.
module fill_pixel_merge
  import fill_pkg::*;
#(
  parameter int unsigned PixBits  = 24,
  parameter int unsigned BurstPix = 64,
  parameter int unsigned BxW      = 16
) (
  input  logic [PixBits*BurstPix-1:0] read_word_i,
  input  logic [BxW-1:0]              bx_i,
  input  logic [COORD_W-1:0]          y_i,
  input  logic [COORD_W-1:0]          x0_i,
  input  logic [COORD_W-1:0]          x1_i,
  input  texture_e                    texture_i,
  input  logic [PixBits-1:0]          color_i,
  output logic [PixBits*BurstPix-1:0] write_word_o
);

  logic [PixBits-1:0] inv_color;
  assign inv_color = ~color_i;

  always_comb begin
    logic [31:0]        x;
    logic [PixBits-1:0] pix;
    write_word_o = read_word_i;
    x            = '0;
    pix          = color_i;
    for (int unsigned p = 0; p < BurstPix; p++) begin
      x = 32'(bx_i) * 32'(BurstPix) + p;
      unique case (texture_i)
        TexSolid:   pix = color_i;
        TexChecker: pix = (x[0] ^ y_i[0]) ? inv_color : color_i;
        TexHStripe: pix = y_i[0] ? inv_color : color_i;
        TexVStripe: pix = x[0] ? inv_color : color_i;
        default:    pix = color_i;
      endcase
      if ((x >= 32'(x0_i)) && (x <= 32'(x1_i))) begin
        write_word_o[p*PixBits +: PixBits] = pix;
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: validates and clamps a request, then read-modify-writes every
// touched SRAM burst word of the rectangle in row-major order, 4 cycles per word.
module rect_fill_engine
  import fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned PIX_BITS   = 24,
  parameter int unsigned BURST_PIX  = DEF_BURST_PIX,
  parameter int unsigned FB_W       = DEF_FB_W,
  parameter int unsigned FB_H       = DEF_FB_H,
  parameter int unsigned NUM_LAYERS = 2,
  localparam int unsigned LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned WORD_W    = PIX_BITS * BURST_PIX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [63:0]         coordinates,
  input  logic [1:0]          texture_code,
  input  logic [PIX_BITS-1:0] color_code,
  input  logic [LAYER_W-1:0]  layer_num,
  output logic                read_enable,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   address,
  input  logic [WORD_W-1:0]   read_data,
  output logic [WORD_W-1:0]   write_data
);

  localparam int unsigned WordsPerRow = calc_words_per_row(FB_W, BURST_PIX);
  localparam int unsigned LayerWords  = calc_layer_words(FB_W, FB_H, BURST_PIX);
  localparam logic [COORD_W-1:0] XMax = COORD_W'(FB_W - 1);
  localparam logic [COORD_W-1:0] YMax = COORD_W'(FB_H - 1);

  state_e                state_q, state_d;
  logic [COORD_W-1:0]    x0_q, y0_q, x1_q, y1_q;
  logic [COORD_W-1:0]    y_q, y_d, bx_q, bx_d;
  logic [COORD_W-1:0]    bx_first, bx_last, start_bx;
  texture_e              tex_q;
  logic [PIX_BITS-1:0]   color_q;
  logic [LAYER_W-1:0]    layer_q;
  logic                  err_q;
  logic [ADDR_W-1:0]     addr_q, next_addr;
  logic [WORD_W-1:0]     wdata_q, merged;
  logic                  reject, last_bx, last_row;

  assign start_bx = COORD_W'(32'(coordinates[63:48]) / BURST_PIX);
  assign bx_first = COORD_W'(32'(x0_q) / BURST_PIX);
  assign bx_last  = COORD_W'(32'(x1_q) / BURST_PIX);
  assign last_bx  = (bx_q == bx_last);
  assign last_row = (y_q == y1_q);

  assign reject = (x1_q < x0_q) || (y1_q < y0_q) || (32'(x0_q) >= FB_W) ||
                  (32'(y0_q) >= FB_H) || (32'(layer_q) >= NUM_LAYERS);

  // Position of the word about to be accessed; used to preload the address register.
  always_comb begin
    y_d  = y_q;
    bx_d = bx_q;
    if (state_q == StNext) begin
      if (last_bx) begin
        bx_d = bx_first;
        y_d  = y_q + COORD_W'(1);
      end else begin
        bx_d = bx_q + COORD_W'(1);
      end
    end
  end

  assign next_addr = ADDR_W'(layer_q) * ADDR_W'(LayerWords) +
                     ADDR_W'(y_d) * ADDR_W'(WordsPerRow) + ADDR_W'(bx_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: state_d = reject ? StFin : StRd;
      StRd:    state_d = StRwait;
      StRwait: state_d = StWr;
      StWr:    state_d = StNext;
      StNext:  state_d = (last_bx && last_row) ? StFin : StRd;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q != StIdle);
    read_enable  = (state_q == StRd);
    write_enable = (state_q == StWr);
    done         = (state_q == StFin);
    err          = (state_q == StFin) && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      y_q     <= '0;
      bx_q    <= '0;
      tex_q   <= TexSolid;
      color_q <= '0;
      layer_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if ((state_q == StIdle) && start) begin
        x0_q    <= coordinates[63:48];
        y0_q    <= coordinates[47:32];
        x1_q    <= coordinates[31:16];
        y1_q    <= coordinates[15:0];
        y_q     <= coordinates[47:32];
        bx_q    <= start_bx;
        tex_q   <= texture_e'(texture_code);
        color_q <= color_code;
        layer_q <= layer_num;
        err_q   <= 1'b0;
      end
      if (state_q == StCheck) begin
        err_q <= reject;
        if (32'(x1_q) > FB_W - 1) x1_q <= XMax;
        if (32'(y1_q) > FB_H - 1) y1_q <= YMax;
      end
      if (((state_q == StCheck) && !reject) || (state_q == StNext)) begin
        addr_q <= next_addr;
      end
      if (state_q == StNext) begin
        y_q  <= y_d;
        bx_q <= bx_d;
      end
      // read_data is valid in RWAIT; hold the merged word for the WR strobe.
      if (state_q == StRwait) begin
        wdata_q <= merged;
      end
    end
  end

  fill_pixel_merge #(
    .PixBits  (PIX_BITS),
    .BurstPix (BURST_PIX),
    .BxW      (COORD_W)
  ) u_merge (
    .read_word_i  (read_data),
    .bx_i         (bx_q),
    .y_i          (y_q),
    .x0_i         (x0_q),
    .x1_i         (x1_q),
    .texture_i    (tex_q),
    .color_i      (color_q),
    .write_word_o (merged)
  );

  assign address    = addr_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomized bench for rect_fill_engine: a behavioural SRAM plus a pixel-level reference
// frame buffer predicts addresses, latency, err and final memory contents.
module tb_rect_fill_engine;

  localparam int PIX     = 24;
  localparam int BURST   = 64;
  localparam int FBW     = 640;
  localparam int FBH     = 480;
  localparam int LAYERS  = 2;
  localparam int WORD_W  = PIX * BURST;
  localparam int WPR     = FBW / BURST;
  localparam int NWORDS  = LAYERS * WPR * FBH;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, err;
  logic [63:0]       coordinates;
  logic [1:0]        texture_code;
  logic [PIX-1:0]    color_code;
  logic [0:0]        layer_num;
  logic              read_enable, write_enable;
  logic [29:0]       address;
  logic [WORD_W-1:0] read_data;
  logic [WORD_W-1:0] write_data;

  logic [WORD_W-1:0] mem     [NWORDS];
  logic [WORD_W-1:0] ref_mem [NWORDS];

  int unsigned rd_q[$];
  int unsigned wr_q[$];
  bit          both_hi;
  bit          err_stray;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  rect_fill_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .coordinates  (coordinates),
    .texture_code (texture_code),
    .color_code   (color_code),
    .layer_num    (layer_num),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .read_data    (read_data),
    .write_data   (write_data)
  );

  // SRAM: one-cycle read latency, write on strobe; also logs the access stream.
  always @(posedge clk) begin
    if (read_enable) begin
      rd_q.push_back(int'(address));
      read_data <= (int'(address) < NWORDS) ? mem[address] : '0;
    end
    if (write_enable) begin
      wr_q.push_back(int'(address));
      if (int'(address) < NWORDS) mem[address] = write_data;
    end
    if (read_enable && write_enable) both_hi = 1'b1;
    if (err && !done) err_stray = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX-1:0] fill_pix(int tex, logic [PIX-1:0] col, int x, int y);
    bit inv;
    case (tex)
      1:       inv = ((x ^ y) & 1) != 0;
      2:       inv = (y & 1) != 0;
      3:       inv = (x & 1) != 0;
      default: inv = 1'b0;
    endcase
    return inv ? ~col : col;
  endfunction

  task automatic run_req(input int x0, input int y0, input int x1, input int y1,
                         input int layer, input int tex, input logic [PIX-1:0] col,
                         input bit poke, input string name);
    int  exp_addr[$];
    bit  eerr;
    int  ex1, ey1, lat, cyc, got_lat, ndone, addr_bad, mem_bad, a;
    bit  busy_bad, err_seen, do_poke;

    eerr = (x1 < x0) || (y1 < y0) || (x0 >= FBW) || (y0 >= FBH) || (layer >= LAYERS);
    if (!eerr) begin
      ex1 = (x1 > FBW - 1) ? FBW - 1 : x1;
      ey1 = (y1 > FBH - 1) ? FBH - 1 : y1;
      for (int y = y0; y <= ey1; y++) begin
        for (int bx = x0 / BURST; bx <= ex1 / BURST; bx++) begin
          a = layer * WPR * FBH + y * WPR + bx;
          exp_addr.push_back(a);
          for (int p = 0; p < BURST; p++) begin
            if (bx * BURST + p >= x0 && bx * BURST + p <= ex1)
              ref_mem[a][p*PIX +: PIX] = fill_pix(tex, col, bx * BURST + p, y);
          end
        end
      end
    end
    lat     = eerr ? 2 : 2 + 4 * exp_addr.size();
    do_poke = poke && !eerr;

    rd_q.delete();
    wr_q.delete();
    both_hi   = 1'b0;
    err_stray = 1'b0;
    busy_bad  = 1'b0;
    err_seen  = 1'b0;
    ndone     = 0;
    got_lat   = 0;
    cyc       = 0;

    coordinates  = {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
    texture_code = 2'(tex);
    color_code   = col;
    layer_num    = 1'(layer);
    start        = 1'b1;
    while (ndone == 0 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (do_poke && cyc == 3) begin
        coordinates = {16'd0, 16'd0, 16'd639, 16'd479};
        start       = 1'b1;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) begin
        ndone++;
        got_lat  = cyc;
        err_seen = err;
      end
    end
    start = 1'b0;
    if (ndone == 0) check_eq({name, "/timeout"}, 1, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
      if (busy !== 1'b0) busy_bad = 1'b1;
    end

    addr_bad = 0;
    foreach (exp_addr[i]) begin
      if (i >= rd_q.size() || rd_q[i] != exp_addr[i]) addr_bad++;
      if (i >= wr_q.size() || wr_q[i] != exp_addr[i]) addr_bad++;
    end
    mem_bad = 0;
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== ref_mem[i]) mem_bad++;

    check_eq({name, "/latency"}, got_lat, lat);
    check_eq({name, "/err"}, err_seen, eerr);
    check_eq({name, "/done_count"}, ndone, 1);
    check_eq({name, "/busy"}, busy_bad, 0);
    check_eq({name, "/n_reads"}, rd_q.size(), exp_addr.size());
    check_eq({name, "/n_writes"}, wr_q.size(), exp_addr.size());
    check_eq({name, "/addr_seq"}, addr_bad, 0);
    check_eq({name, "/enables_overlap"}, both_hi, 0);
    check_eq({name, "/err_without_done"}, err_stray, 0);
    check_eq({name, "/mem"}, mem_bad, 0);
  endtask

  initial begin
    int x0, y0, w, h;
    rst          = 1'b1;
    start        = 1'b0;
    coordinates  = '0;
    texture_code = '0;
    color_code   = '0;
    layer_num    = '0;
    for (int i = 0; i < NWORDS; i++) begin
      for (int k = 0; k < WORD_W / 32; k++) mem[i][k*32 +: 32] = $urandom();
    end
    mem[0] = '0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {busy, done, err, read_enable, write_enable,
                               address != '0, write_data != '0}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_req(0, 0, 63, 0, 0, 0, 24'hFF0000, 1'b0, "solid_word0");
    check_eq("solid_word0/pix0", mem[0][0 +: PIX], 24'hFF0000);
    check_eq("solid_word0/pix63", mem[0][63*PIX +: PIX], 24'hFF0000);
    run_req(60, 2, 70, 2, 1, 1, 24'h00FF00, 1'b0, "checker_span");
    check_eq("checker_span/x60", mem[4820][60*PIX +: PIX], 24'h00FF00);
    check_eq("checker_span/x61", mem[4820][61*PIX +: PIX], 24'hFF00FF);
    check_eq("checker_span/x64", mem[4821][0 +: PIX], 24'h00FF00);
    run_req(600, 479, 700, 479, 0, 3, 24'h123456, 1'b0, "clamp_x1");
    check_eq("clamp_x1/addr", (rd_q.size() > 0) ? rd_q[0] : 0, 479 * 10 + 9);
    run_req(10, 5, 5, 5, 0, 0, 24'h0000FF, 1'b0, "x1_lt_x0");
    run_req(5, 9, 8, 3, 1, 2, 24'h0000FF, 1'b0, "y1_lt_y0");
    run_req(640, 0, 650, 0, 0, 0, 24'h0000FF, 1'b0, "x0_oob");
    run_req(0, 480, 5, 480, 0, 0, 24'h0000FF, 1'b0, "y0_oob");
    run_req(100, 7, 300, 9, 1, 2, 24'hC0FFEE, 1'b1, "start_while_busy");

    // Reset in the middle of a long fill, then resync the reference to what was written.
    coordinates  = {16'd0, 16'd10, 16'd639, 16'd30};
    layer_num    = 1'b1;
    texture_code = 2'd0;
    color_code   = 24'hABCDEF;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check_eq("rst_mid/busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid/outputs", {busy, done, err, read_enable, write_enable,
                                 address != '0, write_data != '0}, 0);
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = mem[i];
    @(posedge clk);
    #1;
    check_eq("rst_mid/idle", busy, 0);
    run_req(130, 40, 260, 41, 0, 1, 24'h5A5A5A, 1'b0, "after_rst");

    for (int t = 0; t < 40; t++) begin
      x0 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 490);
      w  = $urandom_range(0, 150);
      h  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0)
        run_req(x0 + w + 1, y0, x0, y0 + h, $urandom_range(0, 1), $urandom_range(0, 3),
                24'($urandom()), 1'b0, $sformatf("rand%0d", t));
      else
        run_req(x0, y0, x0 + w, y0 + h, $urandom_range(0, 1), $urandom_range(0, 3),
                24'($urandom()), $urandom_range(0, 3) == 0, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
